// File: rtl/siso_pkg.sv
// Shared constants for the serial-in serial-out delay line.
package siso_pkg;

    localparam int SisoWidthDefault = 4;
    localparam int SisoWidthMax     = 64;

endpackage

// File: rtl/siso_stage.sv
// One delay-line stage: a D flop with asynchronous active-low reset to RESET_VAL.
module siso_stage #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/siso.sv
// Serial-in serial-out shift register: delays serial_in by exactly WIDTH clock cycles.
module siso
    import siso_pkg::*;
#(
    parameter int   WIDTH     = SisoWidthDefault,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    output logic serial_out
);

    if (WIDTH < 1 || WIDTH > SisoWidthMax) begin : g_width_check
        $error("siso: WIDTH must be in 1..%0d", SisoWidthMax);
    end

    // Stage outputs gathered LSB-first; bit WIDTH-1 is the oldest sample.
    logic [WIDTH-1:0] shift_reg;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic stage_d;

        if (i == 0) begin : g_head
            assign stage_d = serial_in;
        end else begin : g_chain
            assign stage_d = shift_reg[i-1];
        end

        siso_stage #(
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d   (stage_d),
            .q   (shift_reg[i])
        );
    end

    assign serial_out = shift_reg[WIDTH-1];

endmodule

// File: tb/tb_siso.sv
// Scoreboard bench for siso: a 4-deep instance plus a 1-deep instance with RESET_VAL=1.
module tb_siso;

    logic clk;
    logic rst;
    logic serial_in;
    logic serial_out;
    logic serial_out1;

    typedef struct {
        string      name;
        logic [3:0] reg_exp;
        logic       out_exp;
        logic       out1_exp;
    } exp_t;

    exp_t sb[$];
    event probe_ev;
    int   total = 0;
    int   bad   = 0;

    siso #(
        .WIDTH     (4),
        .RESET_VAL (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .serial_out (serial_out)
    );

    siso #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .serial_out (serial_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pops one expectation per falling edge, or immediately on a mid-cycle probe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or probe_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (dut.shift_reg !== e.reg_exp) begin
                    bad++;
                    $display("FAIL %s shift_reg: got %b want %b", e.name, dut.shift_reg,
                             e.reg_exp);
                end
                total++;
                if (serial_out !== e.out_exp) begin
                    bad++;
                    $display("FAIL %s serial_out: got %b want %b", e.name, serial_out,
                             e.out_exp);
                end
                total++;
                if (serial_out1 !== e.out1_exp) begin
                    bad++;
                    $display("FAIL %s serial_out(w1): got %b want %b", e.name, serial_out1,
                             e.out1_exp);
                end
            end
        end
    end

    // Drive one bit across the next rising edge and record the expected post-edge state.
    task automatic cycle(input logic din, input logic [3:0] r, input logic o, input string nm);
        serial_in = din;
        @(posedge clk);
        #1;
        sb.push_back('{nm, r, o, din});
    endtask

    initial begin
        rst       = 1'b0;
        serial_in = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        sb.push_back('{"reset", 4'b0000, 1'b0, 1'b1});
        #6;
        rst = 1'b1;

        // Stream 0,1,0,1,0,1,1,0,0 then flush with zeros
        cycle(1'b0, 4'b0000, 1'b0, "s1");
        cycle(1'b1, 4'b0001, 1'b0, "s2");
        cycle(1'b0, 4'b0010, 1'b0, "s3");
        cycle(1'b1, 4'b0101, 1'b0, "s4");
        cycle(1'b0, 4'b1010, 1'b1, "s5");
        cycle(1'b1, 4'b0101, 1'b0, "s6");
        cycle(1'b1, 4'b1011, 1'b1, "s7");
        cycle(1'b0, 4'b0110, 1'b0, "s8");
        cycle(1'b0, 4'b1100, 1'b1, "s9");
        cycle(1'b0, 4'b1000, 1'b1, "s10");
        cycle(1'b0, 4'b0000, 1'b0, "s11");
        cycle(1'b0, 4'b0000, 1'b0, "s12");

        // Load all ones, then reset asynchronously mid low phase
        cycle(1'b1, 4'b0001, 1'b0, "load1");
        cycle(1'b1, 4'b0011, 1'b0, "load2");
        cycle(1'b1, 4'b0111, 1'b0, "load3");
        cycle(1'b1, 4'b1111, 1'b1, "load4");
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        sb.push_back('{"async_rst", 4'b0000, 1'b0, 1'b1});
        -> probe_ev;
        @(posedge clk);
        #1;
        sb.push_back('{"rst_hold", 4'b0000, 1'b0, 1'b1});
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Reset mid-stream: two ones in flight must never reach the output
        cycle(1'b1, 4'b0001, 1'b0, "mid1");
        cycle(1'b1, 4'b0011, 1'b0, "mid2");
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        sb.push_back('{"mid_rst", 4'b0000, 1'b0, 1'b1});
        -> probe_ev;
        @(posedge clk);
        #1;
        sb.push_back('{"mid_hold", 4'b0000, 1'b0, 1'b1});
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Held one: output rises exactly after the 4th edge
        cycle(1'b1, 4'b0001, 1'b0, "hold1");
        cycle(1'b1, 4'b0011, 1'b0, "hold2");
        cycle(1'b1, 4'b0111, 1'b0, "hold3");
        cycle(1'b1, 4'b1111, 1'b1, "hold4");
        cycle(1'b1, 4'b1111, 1'b1, "hold5");
        cycle(1'b1, 4'b1111, 1'b1, "hold6");

        // Mixed pattern exercising the 1-deep instance
        cycle(1'b0, 4'b1110, 1'b1, "w1a");
        cycle(1'b1, 4'b1101, 1'b1, "w1b");
        cycle(1'b0, 4'b1010, 1'b1, "w1c");
        cycle(1'b0, 4'b0100, 1'b0, "w1d");
        cycle(1'b1, 4'b1001, 1'b1, "w1e");

        // Drain with a bounded wait
        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
